dmem_port_arbiter: RTL

Shares the single data-memory port between the core's Memory stage and one external master, such as the UART loader or a debug DMA. It drives `mem_hold` to stall the pipeline whenever the core loses arbitration. It sits between the core's `mem_*` outputs and the data BRAM, with the core on one side and the external master on the other. It provides core-priority arbitration with an anti-starvation counter, a lock mode for bulk programming, and 1-cycle read-return routing.

---
 rtl/dmem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the core's
// Memory stage and one external master (UART loader, debug DMA, ...).
// Core has priority. A wait counter bounds how long the external master can
// be starved. A lock mode lets the external master stream bulk writes, and
// read data is routed back one cycle after the read was issued.
//
// Handshake: ext_req is a request held stable by the external master until
// ext_gnt pulses. ext_gnt=1 means the access is on mem_* in that same cycle.
// For a read, ext_rvalid pulses exactly once in the following cycle.
// The core side is stall-based. While mem_hold=1 the core must re-present the
// same request in the next cycle.
module dmem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [3:0]  core_en,
  input  logic        core_wea,
  input  logic        core_rea,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_din,
  output logic [31:0] core_dout,
  output logic        mem_hold,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [3:0]  ext_be,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_din,
  input  logic        ext_lock,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [3:0]  mem_en,
  output logic        mem_wea,
  output logic        mem_rea,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [1:0]  dbg_last_owner,
  output logic [3:0]  dbg_wait_cnt,
  output logic        dbg_lock
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    EXT_RD  = 2'd2,
    OTHER   = 2'd3
  } owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  owner_t      r_last_owner;
  logic [3:0]  r_wait_cnt;
  logic        r_lock_q;
  logic [31:0] r_core_dout_q;

  logic        w_core_req;
  logic        w_core_win;
  logic        w_ext_issue;
  logic [3:0]  w_wait_inc;

  // Grant decision: core first unless starving ext or locked out
  always_comb begin
    w_core_req  = core_rea | core_wea;
    w_core_win  = w_core_req & ~r_lock_q & (r_wait_cnt < MAX_WAIT_C);
    w_ext_issue = ext_req & ~w_core_win;
    w_wait_inc  = (r_wait_cnt < MAX_WAIT_C) ? (r_wait_cnt + 4'd1) : r_wait_cnt;
  end

  // Port mux: winner drives the memory; idle port is all zeros
  always_comb begin
    mem_en   = 4'd0;
    mem_wea  = 1'b0;
    mem_rea  = 1'b0;
    mem_addr = 32'd0;
    mem_din  = 32'd0;
    if (w_core_win) begin
      mem_en   = core_en;
      mem_wea  = core_wea;
      mem_rea  = core_rea;
      mem_addr = core_addr;
      mem_din  = core_din;
    end else if (w_ext_issue) begin
      mem_en   = ext_be;
      mem_wea  = ext_we;
      mem_rea  = ~ext_we;
      mem_addr = ext_addr;
      mem_din  = ext_din;
    end
  end

  // Stall, grant pulse and read-return routing from last cycle's owner
  always_comb begin
    mem_hold   = w_core_req & ~w_core_win;
    ext_gnt    = w_ext_issue;
    ext_rvalid = (r_last_owner == EXT_RD);
    ext_rdata  = (r_last_owner == EXT_RD) ? mem_dout : 32'd0;
    core_dout  = (r_last_owner == CORE_RD) ? mem_dout : r_core_dout_q;
  end

  // Debug visibility of the arbiter state
  always_comb begin
    dbg_last_owner = r_last_owner;
    dbg_wait_cnt   = r_wait_cnt;
    dbg_lock       = r_lock_q;
  end

  // Arbiter state: last_owner FSM, starvation counter, lock flag, load hold
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_last_owner  <= IDLE;
      r_wait_cnt    <= 4'd0;
      r_lock_q      <= 1'b0;
      r_core_dout_q <= 32'd0;
    end else begin
      // last_owner: which read, if any, returns data next cycle
      if (w_core_win) begin
        if (core_wea)
          r_last_owner <= OTHER;
        else
          r_last_owner <= CORE_RD;
      end else if (w_ext_issue) begin
        if (ext_we)
          r_last_owner <= OTHER;
        else
          r_last_owner <= EXT_RD;
      end else begin
        r_last_owner <= IDLE;
      end

      // Starvation counter: counts core wins over a pending external request
      if (w_ext_issue || !ext_req)
        r_wait_cnt <= 4'd0;
      else if (w_core_win)
        r_wait_cnt <= w_wait_inc;

      // Lock: taken on a locked grant, released as soon as ext_lock drops
      if (!ext_lock)
        r_lock_q <= 1'b0;
      else if (w_ext_issue)
        r_lock_q <= 1'b1;

      // Keep the core's load result stable across later stall cycles
      if (r_last_owner == CORE_RD)
        r_core_dout_q <= mem_dout;
    end
  end

endmodule
